// File: rtl/cpu_clk_gen.sv
// CPU clock generator: divides system_clk into a free-running, haltable and
// single-steppable CPU clock, with edge ticks and a rising-edge counter.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_RUN     | free-running, clk toggles at every phase boundary
// ST_HALTED  | clk parked high, cnt parked at 0, waiting for run or step
// ST_STEP_LO | low half of a single-step period
// ST_STEP_HI | high half of a single-step period, then back to ST_HALTED
module cpu_clk_gen #(
  parameter int CNT_W        = 5,
  parameter int DEFAULT_HALF = 16,
  parameter int CYC_W        = 32
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] half_i,
  output logic             clk,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             halted,
  output logic [CYC_W-1:0] cyc_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HALTED  = 2'b01,
    ST_STEP_LO = 2'b10,
    ST_STEP_HI = 2'b11
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             boundary;

  assign boundary = (cnt_q == half_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    half_d  = half_q;
    clk_d   = clk_q;

    case (state_q)
      ST_RUN: begin
        if (boundary) begin
          cnt_d  = '0;
          half_d = half_i;
          // Any non-run mode parks clk high at this boundary: a low phase
          // ends with a rise, a high phase simply stays high.
          if (mode == MODE_RUN) begin
            clk_d = ~clk_q;
          end else begin
            clk_d   = 1'b1;
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        cnt_d = '0;
        clk_d = 1'b1;
        if (mode == MODE_RUN) begin
          state_d = ST_RUN;
          half_d  = half_i;
        end else if (mode == MODE_STEP && step_req) begin
          state_d = ST_STEP_LO;
          clk_d   = 1'b0;
          half_d  = half_i;
        end
      end
      ST_STEP_LO: begin
        if (boundary) begin
          cnt_d   = '0;
          half_d  = half_i;
          clk_d   = 1'b1;
          state_d = ST_STEP_HI;
        end
      end
      ST_STEP_HI: begin
        if (boundary) begin
          cnt_d   = '0;
          half_d  = half_i;
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    // Ticks are computed from the next clk value so they line up with it.
    rise_d = clk_d & ~clk_q;
    fall_d = ~clk_d & clk_q;
    cyc_d  = rise_d ? cyc_q + 1'b1 : cyc_q;
  end

  always_ff @(posedge system_clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      half_q  <= CNT_W'(DEFAULT_HALF);
      clk_q   <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cyc_q   <= cyc_d;
    end
  end

  assign clk       = clk_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign halted    = (state_q == ST_HALTED);
  assign cyc_cnt   = cyc_q;

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: directed scenario tasks plus a randomized run
// checked against a phase-length reference model.
module tb_cpu_clk_gen;

  localparam int DEF_HALF = 16;

  logic        system_clk = 1'b0;
  logic        reset_n    = 1'b1;
  logic [1:0]  mode       = 2'b00;
  logic        step_req   = 1'b0;
  logic [4:0]  half_i     = 5'd16;
  logic        clk, rise_tick, fall_tick, halted;
  logic [31:0] cyc_cnt;
  logic        clk4, rise4, fall4, halted4;
  logic [3:0]  cyc4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase length countdown, not a copy of the up-counter.
  logic        m_clk, m_rise, m_fall, m_halted;
  int          m_step;   // 0 none, 1 low half of step, 2 high half of step
  int          m_left;   // cycles remaining in the current clk phase
  logic [31:0] m_cyc;

  cpu_clk_gen dut (
    .system_clk(system_clk), .reset(reset_n), .mode(mode), .step_req(step_req),
    .half_i(half_i), .clk(clk), .rise_tick(rise_tick), .fall_tick(fall_tick),
    .halted(halted), .cyc_cnt(cyc_cnt)
  );

  cpu_clk_gen #(.CYC_W(4)) dut4 (
    .system_clk(system_clk), .reset(reset_n), .mode(mode), .step_req(step_req),
    .half_i(half_i), .clk(clk4), .rise_tick(rise4), .fall_tick(fall4),
    .halted(halted4), .cyc_cnt(cyc4)
  );

  always #5 system_clk = ~system_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_clk = 1'b1; m_rise = 1'b0; m_fall = 1'b0; m_halted = 1'b0;
    m_step = 0; m_left = DEF_HALF + 1; m_cyc = '0;
  endtask

  task automatic model_step();
    logic prev;
    prev = m_clk;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (m_halted) begin
      m_clk = 1'b1;
      if (mode == 2'b00) begin
        m_halted = 1'b0; m_left = int'(half_i) + 1;
      end else if (mode == 2'b10 && step_req) begin
        m_halted = 1'b0; m_step = 1; m_clk = 1'b0; m_left = int'(half_i) + 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_left = int'(half_i) + 1;
        if (m_step == 1) begin
          m_clk = 1'b1; m_step = 2;
        end else if (m_step == 2) begin
          m_step = 0; m_halted = 1'b1;
        end else if (mode == 2'b00) begin
          m_clk = ~m_clk;
        end else begin
          m_clk = 1'b1; m_halted = 1'b1;
        end
      end
    end
    m_rise = !prev && m_clk;
    m_fall = prev && !m_clk;
    if (m_rise) m_cyc = m_cyc + 1;
  endtask

  // Every system_clk edge goes through here so the model never drifts.
  task automatic tick();
    @(posedge system_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({clk, rise_tick, fall_tick, halted} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: got clk/rise/fall/halted=%b expected 1000",
               {clk, rise_tick, fall_tick, halted});
    end
    n_checks++;
    if (cyc_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cyc: got %0d expected 0", cyc_cnt);
    end
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if ({clk, halted, cyc_cnt} !== {1'b1, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL reset_held: got clk=%b halted=%b cyc=%0d expected 1 0 0",
                         clk, halted, cyc_cnt);
    end
  endtask

  task automatic test_run_default();
    int n;
    @(negedge system_clk);
    mode = 2'b00; half_i = 5'd16; reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (fall_tick) break;
    end
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL first_fall_edge: got %0d expected 17", n);
    end
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (rise_tick) break;
    end
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL low_phase_len: got %0d expected 17", n);
    end
    n_checks++;
    if (cyc_cnt !== 32'd1) begin
      n_fail++; $display("FAIL cyc_first_rise: got %0d expected 1", cyc_cnt);
    end
  endtask

  task automatic test_half_change();
    int n;
    logic prev;
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); n++; end
    half_i = 5'd3;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (fall_tick) break;
    end
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL mid_phase_half_change: got %0d expected 17", n);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (rise_tick) break; end
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL half3_low: got %0d expected 4", n);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (fall_tick) break; end
    half_i = 5'd0;
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL half3_high: got %0d expected 4", n);
    end
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); n++; if (rise_tick) break; end
    n_checks++;
    if (n !== 4) begin
      n_fail++; $display("FAIL half0_pending_low: got %0d expected 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      prev = clk;
      tick();
      n_checks++;
      if (clk !== ~prev || (rise_tick && fall_tick)) begin
        n_fail++; $display("FAIL half0_toggle: got clk=%b rise=%b fall=%b expected clk=%b",
                           clk, rise_tick, fall_tick, ~prev);
      end
    end
  endtask

  task automatic test_halt();
    int  n;
    bit  bad;
    half_i = 5'd16;
    for (int i = 0; i < 40; i++) begin tick(); if (fall_tick) break; end
    for (int i = 0; i < 40; i++) begin tick(); if (rise_tick) break; end
    for (int i = 0; i < 5; i++) tick();
    mode = 2'b01;
    n = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); n++;
      if (fall_tick || !clk) bad = 1;
      if (halted) break;
    end
    n_checks++;
    if (n !== 12) begin
      n_fail++; $display("FAIL halt_delay: got %0d expected 12", n);
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL halt_no_fall: got a fall or clk low, expected clk held 1");
    end
    mode = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if ({halted, clk, rise_tick, fall_tick} !== 4'b1100) begin
      n_fail++; $display("FAIL halt_mode11: got halted/clk/rise/fall=%b expected 1100",
                         {halted, clk, rise_tick, fall_tick});
    end
  endtask

  task automatic test_step();
    int          n;
    logic [31:0] cyc0;
    cyc0 = cyc_cnt;
    mode = 2'b10; half_i = 5'd16; step_req = 1'b1;
    tick();
    step_req = 1'b0;
    n_checks++;
    if ({clk, fall_tick, halted} !== 3'b010) begin
      n_fail++; $display("FAIL step_start: got clk/fall/halted=%b expected 010",
                         {clk, fall_tick, halted});
    end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step_req = (i == 3);
      tick();
      if (clk) break;
      n++;
    end
    step_req = 1'b0;
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL step_low_len: got %0d expected 17", n);
    end
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step_req = (i == 5);
      tick();
      if (halted) break;
      n++;
    end
    step_req = 1'b0;
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL step_high_len: got %0d expected 17", n);
    end
    n_checks++;
    if (cyc_cnt !== cyc0 + 32'd1) begin
      n_fail++; $display("FAIL step_cyc: got %0d expected %0d", cyc_cnt, cyc0 + 32'd1);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if ({halted, clk} !== 2'b11) begin
      n_fail++; $display("FAIL step_not_queued: got halted/clk=%b expected 11", {halted, clk});
    end
  endtask

  task automatic test_reset_mid_step();
    int n;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({clk, halted, rise_tick, fall_tick, cyc_cnt} !== {4'b1000, 32'd0}) begin
      n_fail++; $display("FAIL reset_mid_step: got clk=%b halted=%b rise=%b fall=%b cyc=%0d expected 1 0 0 0 0",
                         clk, halted, rise_tick, fall_tick, cyc_cnt);
    end
    @(negedge system_clk);
    mode = 2'b00; half_i = 5'd16; reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin tick(); n++; if (fall_tick) break; end
    n_checks++;
    if (n !== 17) begin
      n_fail++; $display("FAIL post_reset_fall: got %0d expected 17", n);
    end
  endtask

  task automatic test_wrap();
    int r;
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge system_clk);
    mode = 2'b00; half_i = 5'd0; reset_n = 1'b1;
    r = 0;
    for (int i = 0; i < 200 && r < 17; i++) begin
      tick();
      if (rise_tick) begin
        r++;
        n_checks++;
        if (cyc4 !== 4'(r % 16) || cyc_cnt !== 32'(r)) begin
          n_fail++; $display("FAIL cyc_wrap: got cyc4=%0d cyc32=%0d expected %0d %0d",
                             cyc4, cyc_cnt, r % 16, r);
        end
      end
    end
    n_checks++;
    if (r !== 17) begin
      n_fail++; $display("FAIL wrap_rises: got %0d expected 17", r);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) half_i = 5'($urandom_range(0, 4));
      step_req = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if ({clk, rise_tick, fall_tick, halted} !== {m_clk, m_rise, m_fall, m_halted}) begin
        n_fail++; $display("FAIL rand_ctrl cycle %0d: got clk/rise/fall/halted=%b expected %b",
                           i, {clk, rise_tick, fall_tick, halted}, {m_clk, m_rise, m_fall, m_halted});
      end
      n_checks++;
      if (cyc_cnt !== m_cyc || cyc4 !== m_cyc[3:0]) begin
        n_fail++; $display("FAIL rand_cyc cycle %0d: got %0d/%0d expected %0d/%0d",
                           i, cyc_cnt, cyc4, m_cyc, m_cyc[3:0]);
      end
    end
    step_req = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_default();
    test_half_change();
    test_halt();
    test_step();
    test_reset_mid_step();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_clk_gen.md
CPU_CLK_GEN -- requirements
Module: cpu_clk_gen

Interface
REQ-001 Parameter CNT_W, default 5, SHALL set the width of the half-period counter and of half_i.
REQ-002 Parameter DEFAULT_HALF, default 16, SHALL set the half-period reload value loaded at reset.
REQ-003 Parameter CYC_W, default 32, SHALL set the width of cyc_cnt.
REQ-004 Port system_clk, input, 1 bit, SHALL be the clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-006 Port mode, input, 2 bits, SHALL select operation: 00 RUN, 01 HALT, 10 STEP, 11 treated as HALT.
REQ-007 Port step_req, input, 1 bit, SHALL be a single-system_clk step request pulse.
REQ-008 Port half_i, input, CNT_W bits, SHALL be the requested half-period minus one, in system_clk cycles.
REQ-009 Port clk, output, 1 bit, SHALL be the registered divided CPU clock.
REQ-010 Port rise_tick, output, 1 bit, SHALL pulse for one cycle when clk goes 0->1.
REQ-011 Port fall_tick, output, 1 bit, SHALL pulse for one cycle when clk goes 1->0.
REQ-012 Port halted, output, 1 bit, SHALL be high while the state is HALTED.
REQ-013 Port cyc_cnt, output, CYC_W bits, SHALL count clk rising edges.

Function
REQ-014 The block SHALL hold state (RUN, HALTED, STEP_LO, STEP_HI), counter cnt, and latched reload half_q.
REQ-015 A boundary SHALL occur on a cycle where cnt==half_q; it clears cnt to 0. Other cycles increment cnt by 1, so each phase lasts half_q+1 system_clk cycles.
REQ-016 half_q SHALL load half_i only at a boundary or on leaving HALTED; half_i changes mid-phase SHALL NOT alter the current phase.
REQ-017 half_i==0 SHALL give a boundary every cycle: clk period of 2 system_clk cycles.
REQ-018 In RUN with mode==00, every boundary SHALL toggle clk.
REQ-019 In RUN with mode!=00 at a boundary: if clk==0, clk SHALL go to 1; if clk==1, clk SHALL stay 1. In both cases the state SHALL go to HALTED. Before the boundary, toggling continues normally.
REQ-020 In HALTED, clk SHALL be held 1 and cnt held at 0.
REQ-021 In HALTED with mode==00, the state SHALL go to RUN next cycle with clk still 1; a full high phase then precedes the first fall.
REQ-022 In HALTED with mode==10 and step_req==1, the state SHALL go to STEP_LO and clk SHALL go to 0 in the same edge, with cnt=0.
REQ-023 STEP_LO SHALL, at its boundary, drive clk to 1 and go to STEP_HI. STEP_HI SHALL, at its boundary, go to HALTED with clk staying 1. One step is exactly one full clk period.
REQ-024 step_req outside HALTED, or with mode!=10, SHALL be ignored and not queued; mode changes during STEP_LO/STEP_HI SHALL take effect only after returning to HALTED.
REQ-025 rise_tick and fall_tick SHALL be registered and asserted in the same cycle clk shows its new value; never both high at once.
REQ-026 cyc_cnt SHALL increment by 1 on each rise_tick (RUN or STEP) and wrap from all-ones to 0.
REQ-027 A cycle that is both a boundary and a mode change SHALL follow REQ-019 using the mode sampled that cycle.

Reset
REQ-028 While reset==0, outputs SHALL be: clk=1, rise_tick=0, fall_tick=0, halted=0, cyc_cnt=0. Internal values SHALL be: cnt=0, half_q=DEFAULT_HALF, state RUN. Reset SHALL act immediately, including mid-step or mid-halt.
REQ-029 After reset release with mode==00, clk SHALL free-run with the first fall on the 17th system_clk rising edge (defaults).

Verification
REQ-030 Default params, mode=00, release reset -> clk high 17 cycles, low 17, period 34; cyc_cnt=1 at first rise_tick.
REQ-031 half_i changed 16->3 mid high phase -> that phase stays 17 cycles; subsequent phases are 4 cycles; half_i=0 -> clk toggles every cycle.
REQ-032 mode=01 asserted while clk high at cnt=5 -> clk stays 1; halted=1 after the boundary (12 cycles later); no fall_tick.
REQ-033 HALTED, mode=10, step_req pulse -> clk 0 for 17 cycles, 1 for 17, then halted=1. cyc_cnt +1. A second step_req during the step is ignored.
REQ-034 reset=0 asserted during STEP_LO -> clk=1, cyc_cnt=0, halted=0 immediately. After release, free-run per REQ-029.
REQ-035 CYC_W=4, run 16 rises -> cyc_cnt wraps 15->0.
